// File: rtl/u_mem_access_unit.sv
// Load/store sequencer in front of the 2048x16 data memory: range check, one-cycle strobe, registered response.
// Optional statistics counters are enabled with `define MEM_ACCESS_STATS_EN.
module u_mem_access_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int REQ_ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [0:REQ_ADDR_WIDTH-1] req_addr,
  input  logic [0:DATA_WIDTH-1]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [0:DATA_WIDTH-1]   resp_data,
  output logic                    resp_err,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [0:MEM_ADDR_WIDTH-1] mem_address,
  output logic [0:DATA_WIDTH-1]   mem_in_data,
`ifdef MEM_ACCESS_STATS_EN
  output logic [0:15]             load_count,
  output logic [0:15]             store_count,
  output logic [0:15]             err_count,
`endif
  input  logic [0:DATA_WIDTH-1]   mem_out_data
);

  localparam int HI_BITS = REQ_ADDR_WIDTH - MEM_ADDR_WIDTH;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]                state_q, state_d;
  logic                      write_q, write_d;
  logic                      req_ready_q, req_ready_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [0:DATA_WIDTH-1]     resp_data_q, resp_data_d;
  logic                      resp_err_q, resp_err_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [0:MEM_ADDR_WIDTH-1] mem_address_q, mem_address_d;
  logic [0:DATA_WIDTH-1]     mem_in_data_q, mem_in_data_d;
  logic                      addr_oob_s;
  logic                      done_load_s;
  logic                      done_store_s;
  logic                      done_err_s;

  assign addr_oob_s = (req_addr[0:HI_BITS-1] != {HI_BITS{1'b0}});

  // STROBE spans two cycles: the first arms the strobe flop, the second holds it high.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_err_d    = resp_err_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_in_data_d = mem_in_data_q;
    done_load_s   = 1'b0;
    done_store_s  = 1'b0;
    done_err_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d       = req_write;
          mem_address_d = req_addr[HI_BITS:REQ_ADDR_WIDTH-1];
          mem_in_data_d = req_wdata;
          if (addr_oob_s) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = {DATA_WIDTH{1'b0}};
            done_err_s   = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = STROBE;
      end
      STROBE: begin
        if (mem_read_q || mem_write_q) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = write_q ? {DATA_WIDTH{1'b0}} : mem_out_data;
          done_load_s  = ~write_q;
          done_store_s = write_q;
        end else begin
          mem_read_d  = ~write_q;
          mem_write_d = write_q;
        end
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= {DATA_WIDTH{1'b0}};
      resp_err_q    <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= {MEM_ADDR_WIDTH{1'b0}};
      mem_in_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_in_data_q <= mem_in_data_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_in_data = mem_in_data_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [0:15] load_count_q, load_count_d;
  logic [0:15] store_count_q, store_count_d;
  logic [0:15] err_count_q, err_count_d;

  // Saturating event counters.
  always_comb begin
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    err_count_d   = err_count_q;
    if (done_load_s && (load_count_q != 16'hFFFF)) begin
      load_count_d = load_count_q + 16'd1;
    end else begin
      load_count_d = load_count_q;
    end
    if (done_store_s && (store_count_q != 16'hFFFF)) begin
      store_count_d = store_count_q + 16'd1;
    end else begin
      store_count_d = store_count_q;
    end
    if (done_err_s && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count_q  <= 16'h0000;
      store_count_q <= 16'h0000;
      err_count_q   <= 16'h0000;
    end else begin
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign load_count  = load_count_q;
  assign store_count = store_count_q;
  assign err_count   = err_count_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = done_load_s ^ done_store_s ^ done_err_s;
`endif

endmodule

// File: tb/tb_u_mem_access_unit.sv
// Scoreboard bench for u_mem_access_unit with a behavioural 2048x16 memory acting on strobe rising edges.
module tb_u_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [0:15] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [0:15] resp_data;
  logic        mem_read, mem_write;
  logic [0:10] mem_address;
  logic [0:15] mem_in_data, mem_out_data;
`ifdef MEM_ACCESS_STATS_EN
  logic [0:15] load_count, store_count, err_count;
`endif

  int checks = 0;
  int errors = 0;
  int n_ld = 0, n_st = 0, n_err = 0;
  logic [15:0] mem [0:2047];
  logic [15:0] ref_mem [0:2047];
  logic [16:0] sb_q [$];

  u_mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_in_data(mem_in_data),
`ifdef MEM_ACCESS_STATS_EN
    .load_count(load_count), .store_count(store_count), .err_count(err_count),
`endif
    .mem_out_data(mem_out_data)
  );

  always #5 clk = ~clk;

  always @(posedge mem_write) mem[mem_address] <= mem_in_data;
  always @(posedge mem_read)  mem_out_data <= mem[mem_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic xact(input logic wr, input logic [15:0] addr, input logic [15:0] wd, input int hold);
    logic        err;
    logic        got;
    logic [15:0] ed;
    logic [16:0] sb;
    int          lat;
    err = (addr[15:11] != 5'd0);
    ed  = (wr || err) ? 16'h0000 : ref_mem[addr[10:0]];
    if (wr && !err) ref_mem[addr[10:0]] = wd;
    sb_q.push_back({err, ed});
    if (err) n_err++;
    else if (wr) n_st++;
    else n_ld++;
    lat = err ? 1 : 3;
    got = 1'b0;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(posedge clk); #1;
      check("mem_read_pulse", mem_read, (!wr && !err && k == 2));
      check("mem_write_pulse", mem_write, (wr && !err && k == 2));
      if (k == 2 && !err) begin
        check("mem_address", mem_address, addr[10:0]);
        if (wr) check("mem_in_data", mem_in_data, wd);
      end
      if (resp_valid) begin
        got = 1'b1;
        check("resp_latency", k, lat);
        sb = sb_q.pop_front();
        check("resp_data", resp_data, sb[15:0]);
        check("resp_err", resp_err, sb[16]);
      end
    end
    if (!got) begin
      check("resp_timeout", 0, 1);
      void'(sb_q.pop_front());
    end else begin
      for (int h = 0; h < hold; h++) begin
        req_valid = (h == 0); req_write = 1'b1; req_addr = 16'h0800;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("hold_valid", resp_valid, 1);
        check("hold_data", resp_data, ed);
        check("hold_err", resp_err, err);
        check("hold_req_ready", req_ready, 0);
        check("hold_no_strobe", {mem_read, mem_write}, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("resp_dropped", resp_valid, 0);
      check("req_ready_back", req_ready, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 16'h0000; req_wdata = 16'h0000; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_strobes", {mem_read, mem_write}, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_in_data", mem_in_data, 0);
    @(negedge clk); rst_n = 1'b1;

    xact(1'b1, 16'h0010, 16'hBEEF, 0);
    xact(1'b0, 16'h0010, 16'h0000, 0);
    xact(1'b0, 16'h0800, 16'h0000, 0);
    xact(1'b0, 16'h07FF, 16'h0000, 0);
    xact(1'b0, 16'h0000, 16'h0000, 5);

    // Store 0x1234 to 0x0005 and hit reset while the write strobe is high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0005; req_wdata = 16'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_strobe_high", mem_write, 1);
    ref_mem[5] = 16'h1234;
    rst_n = 1'b0;
    #1;
    check("abort_strobe_low", mem_write, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_req_ready", req_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    n_ld = 0; n_st = 0; n_err = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_resp", resp_valid, 0);
    end

    xact(1'b0, 16'h0005, 16'h0000, 0);
    xact(1'b1, 16'h0020, 16'h55AA, 0);
    xact(1'b0, 16'h0020, 16'h0000, 0);
    xact(1'b1, 16'h07FF, 16'hA5C3, 0);
    xact(1'b0, 16'h07FF, 16'h0000, 0);
    xact(1'b1, 16'hFFFF, 16'h0BAD, 0);
    check("sb_empty", sb_q.size(), 0);
`ifdef MEM_ACCESS_STATS_EN
    check("load_count", load_count, n_ld);
    check("store_count", store_count, n_st);
    check("err_count", err_count, n_err);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Strobes must never overlap.
  always @(negedge clk) begin
    if (rst_n && mem_read && mem_write) check("strobe_overlap", 1, 0);
  end

endmodule
